// File: rtl/apb_master_bridge.sv
// APB requester: turns a valid/ready command into an APB SETUP+ACCESS transfer and a one-cycle response pulse.
// Latency: accept at edge N, response pulse after edge N+2 with zero wait states; one transfer per 2 cycles back-to-back.
// Backpressure: cmd_ready only in IDLE or on the completing/aborting ACCESS cycle; rsp_valid has no backpressure.
module apb_master_bridge #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  pclk,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  pwrite,
    output logic                  psel,
    output logic                  penable,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // A zero TIMEOUT still needs a legal (unused) counter width.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Counter is cleared on the first ACCESS cycle, so the TIMEOUT-th cycle sees TIMEOUT-1.
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic timeout_fire;
    logic xfer_done;
    logic accept;

    // Completion / abort decode for the current ACCESS cycle, and the command handshake.
    always_comb begin
        timeout_fire = (TIMEOUT > 0) && (state_q == ST_ACCESS) && !pready && (cnt_q == CNT_LAST);
        xfer_done    = (state_q == ST_ACCESS) && (pready || timeout_fire);
        cmd_ready    = (state_q == ST_IDLE) || xfer_done;
        accept       = cmd_valid && cmd_ready;
        busy         = (state_q != ST_IDLE);
    end

    // State register; reset drops the bus immediately and discards any transfer in flight.
    always_ff @(posedge pclk or posedge PRESET) begin
        if (PRESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: SETUP always lasts one cycle; a finishing ACCESS chains straight into a new SETUP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (xfer_done) state_d = accept ? ST_SETUP : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values: bus controls follow the next state, response captured on completion.
    always_comb begin
        cnt_d       = cnt_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_valid_d = xfer_done;
        psel_d      = (state_d != ST_IDLE);
        penable_d   = (state_d == ST_ACCESS);

        if (state_q == ST_SETUP) begin
            cnt_d = '0;
        end else if ((state_q == ST_ACCESS) && !pready && (cnt_q != '1)) begin
            cnt_d = cnt_q + CW'(1);
        end

        if (accept) begin
            paddr_d  = cmd_addr;
            pwrite_d = cmd_write;
            pwdata_d = cmd_wdata;
        end

        if (xfer_done) begin
            rsp_err_d   = timeout_fire;
            rsp_rdata_d = (pready && !pwrite_q) ? prdata : '0;
        end
    end

    // Registered outputs and wait counter.
    always_ff @(posedge pclk or posedge PRESET) begin
        if (PRESET) begin
            cnt_q       <= '0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign paddr     = paddr_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge with a small APB memory slave (programmable wait states / hang).
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: slave pready is withheld via slv_wait / slv_hang.
module tb_apb_master_bridge;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          pclk;
    logic          PRESET;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          busy;
    logic [AW-1:0] paddr;
    logic          pwrite;
    logic          psel;
    logic          penable;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;

    int n_vec = 0;
    int n_err = 0;

    apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(4)) dut (
        .pclk(pclk), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
        .pwdata(pwdata), .prdata(prdata), .pready(pready)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // ---------------- APB memory slave ----------------
    logic [DW-1:0] mem [0:1023];
    logic [DW-1:0] ref_mem [0:1023];
    bit            mem_init = 1'b0;
    bit            slv_hang = 1'b0;
    int            slv_wait = 0;
    int            acc_cnt = 0;

    assign pready = psel && penable && !slv_hang && (acc_cnt >= slv_wait);
    assign prdata = mem[paddr];

    always @(posedge pclk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
        end else if (psel && penable && pready && pwrite) begin
            mem[paddr] <= pwdata;
        end
    end

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // Drive one command, wait for accept and response (bounded); returns response and edges from accept.
    task automatic do_xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output bit ok, output logic [DW-1:0] rd, output logic er, output int lat);
        bit acc;
        acc = 1'b0; ok = 1'b0; rd = '0; er = 1'b0; lat = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = cmd_ready;
            step();
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 50 && acc && !ok; i++) begin
            lat++;
            if (rsp_valid) begin
                ok = 1'b1; rd = rsp_rdata; er = rsp_err;
            end else begin
                step();
            end
        end
    endtask

    task automatic test_reset();
        PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        mem_init = 1'b1;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'hC0DE_0000 | 32'(i);
        #12;
        n_vec++; if ({psel, penable, pwrite} !== 3'b000) begin n_err++; $display("FAIL reset_ctrl got psel/pen/pwrite=%b want 000", {psel, penable, pwrite}); end
        n_vec++; if ({paddr, pwdata} !== '0) begin n_err++; $display("FAIL reset_addr_data got paddr=%h pwdata=%h want 0", paddr, pwdata); end
        n_vec++; if ({rsp_valid, rsp_err, rsp_rdata} !== '0) begin n_err++; $display("FAIL reset_rsp got v=%b e=%b d=%h want 0", rsp_valid, rsp_err, rsp_rdata); end
        n_vec++; if ({cmd_ready, busy} !== 2'b10) begin n_err++; $display("FAIL reset_ready_busy got %b want 10", {cmd_ready, busy}); end
        @(negedge pclk);
        mem_init = 1'b0;
        PRESET = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_access();
        slv_hang = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h55;
        step();                    // SETUP
        cmd_valid = 1'b0;
        step();                    // ACCESS 1
        step();                    // ACCESS 2
        n_vec++; if ({psel, penable} !== 2'b11) begin n_err++; $display("FAIL midrst_pre got psel/pen=%b want 11", {psel, penable}); end
        #2 PRESET = 1'b1;
        #1;
        n_vec++; if ({psel, penable} !== 2'b00) begin n_err++; $display("FAIL midrst_async got psel/pen=%b want 00", {psel, penable}); end
        n_vec++; if ({busy, rsp_valid} !== 2'b00) begin n_err++; $display("FAIL midrst_busy got busy/rv=%b want 00", {busy, rsp_valid}); end
        @(negedge pclk);
        PRESET = 1'b0;
        slv_hang = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            n_vec++; if ({cmd_ready, busy, rsp_valid} !== 3'b100) begin n_err++; $display("FAIL midrst_after c%0d got rdy/busy/rv=%b want 100", c, {cmd_ready, busy, rsp_valid}); end
        end
    endtask

    task automatic test_write_read();
        bit ok; logic [DW-1:0] rd; logic er; int lat;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h2A5; cmd_wdata = 32'hABCD_1234;
        step();
        cmd_valid = 1'b0;
        n_vec++; if ({psel, penable, pwrite, busy, cmd_ready} !== 5'b10110) begin n_err++; $display("FAIL wr_setup got sel/en/wr/busy/rdy=%b want 10110", {psel, penable, pwrite, busy, cmd_ready}); end
        n_vec++; if ({paddr, pwdata} !== {10'h2A5, 32'hABCD_1234}) begin n_err++; $display("FAIL wr_setup_bus got %h/%h want 2a5/abcd1234", paddr, pwdata); end
        step();
        n_vec++; if ({psel, penable, cmd_ready, rsp_valid} !== 4'b1110) begin n_err++; $display("FAIL wr_access got sel/en/rdy/rv=%b want 1110", {psel, penable, cmd_ready, rsp_valid}); end
        step();
        n_vec++; if ({psel, penable, rsp_valid, rsp_err} !== 4'b0010) begin n_err++; $display("FAIL wr_rsp got sel/en/rv/err=%b want 0010", {psel, penable, rsp_valid, rsp_err}); end
        n_vec++; if (rsp_rdata !== 32'h0) begin n_err++; $display("FAIL wr_rdata got %h want 0", rsp_rdata); end
        step();
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL wr_pulse got rv=%b want 0", rsp_valid); end
        do_xfer(1'b0, 10'h2A5, 32'hFFFF_FFFF, ok, rd, er, lat);
        n_vec++; if ({ok, er} !== 2'b10) begin n_err++; $display("FAIL rd_rsp got ok/err=%b want 10", {ok, er}); end
        n_vec++; if (rd !== 32'hABCD_1234) begin n_err++; $display("FAIL rd_data got %h want abcd1234", rd); end
        n_vec++; if (lat !== 3) begin n_err++; $display("FAIL rd_latency got %0d want 3", lat); end
        step();
        n_vec++; if ({rsp_valid, rsp_rdata} !== {1'b0, 32'hABCD_1234}) begin n_err++; $display("FAIL rd_hold got rv=%b d=%h want 0/abcd1234", rsp_valid, rsp_rdata); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a [3];
        logic [DW-1:0] d [3];
        bit [7:0] got_sel, got_pen, got_rv;
        int k; bit go;
        a[0] = 10'd1; a[1] = 10'd2; a[2] = 10'd3;
        d[0] = 32'h11; d[1] = 32'h22; d[2] = 32'h33;
        got_sel = '0; got_pen = '0; got_rv = '0; k = 0;
        step();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a[0]; cmd_wdata = d[0];
        for (int c = 1; c <= 7; c++) begin
            go = cmd_valid && cmd_ready;
            step();
            if (go) begin
                k++;
                if (k < 3) begin cmd_addr = a[k]; cmd_wdata = d[k]; end
                else cmd_valid = 1'b0;
            end
            got_sel[c] = psel; got_pen[c] = penable; got_rv[c] = rsp_valid;
        end
        cmd_valid = 1'b0;
        n_vec++; if (got_sel !== 8'h7E) begin n_err++; $display("FAIL b2b_psel got %b want 01111110", got_sel); end
        n_vec++; if (got_pen !== 8'h54) begin n_err++; $display("FAIL b2b_penable got %b want 01010100", got_pen); end
        n_vec++; if (got_rv !== 8'hA8) begin n_err++; $display("FAIL b2b_rsp got %b want 10101000", got_rv); end
        n_vec++; if ({mem[1], mem[2], mem[3]} !== {32'h11, 32'h22, 32'h33}) begin n_err++; $display("FAIL b2b_mem got %h %h %h want 11 22 33", mem[1], mem[2], mem[3]); end
        for (int i = 0; i < 3; i++) ref_mem[a[i]] = d[i];
    endtask

    task automatic test_wait_states();
        bit ok; logic [DW-1:0] rd; logic er; int lat; int rsp_at;
        do_xfer(1'b1, 10'h010, 32'h5A5A_5A5A, ok, rd, er, lat);
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL ws_prewrite got ok=%b want 1", ok); end
        slv_wait = 3;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h010;
        step();
        cmd_valid = 1'b0;
        rsp_at = -1; rd = '0; er = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            if (rsp_valid && rsp_at < 0) begin rsp_at = c; rd = rsp_rdata; er = rsp_err; end
            if (psel) begin
                n_vec++; if (paddr !== 10'h010) begin n_err++; $display("FAIL ws_paddr c%0d got %h want 010", c, paddr); end
            end
            step();
        end
        n_vec++; if (rsp_at !== 6) begin n_err++; $display("FAIL ws_latency got cycle %0d want 6", rsp_at); end
        n_vec++; if ({rd, er} !== {32'h5A5A_5A5A, 1'b0}) begin n_err++; $display("FAIL ws_rsp got d=%h e=%b want 5a5a5a5a/0", rd, er); end
        slv_wait = 0;
    endtask

    task automatic test_timeout();
        slv_hang = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h010;
        step();                                           // c1 SETUP
        cmd_write = 1'b1; cmd_addr = 10'h030; cmd_wdata = 32'h77;
        n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL to_setup_rdy got %b want 0", cmd_ready); end
        step(); step(); step();                           // c4 ACCESS 3
        n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL to_c4_rdy got %b want 0", cmd_ready); end
        step();                                           // c5 ACCESS 4, timeout fires
        n_vec++; if ({cmd_ready, penable} !== 2'b11) begin n_err++; $display("FAIL to_c5 got rdy/en=%b want 11", {cmd_ready, penable}); end
        step();                                           // c6 abort response + new SETUP
        cmd_valid = 1'b0;
        slv_hang = 1'b0;
        n_vec++; if ({psel, penable, paddr} !== {2'b10, 10'h030}) begin n_err++; $display("FAIL to_next_setup got sel/en=%b paddr=%h want 10/030", {psel, penable}, paddr); end
        n_vec++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b11, 32'h0}) begin n_err++; $display("FAIL to_rsp got v=%b e=%b d=%h want 1/1/0", rsp_valid, rsp_err, rsp_rdata); end
        step();                                           // c7 ACCESS
        n_vec++; if ({penable, rsp_valid} !== 2'b10) begin n_err++; $display("FAIL to_next_access got en/rv=%b want 10", {penable, rsp_valid}); end
        step();                                           // c8 response
        n_vec++; if ({rsp_valid, rsp_err} !== 2'b10) begin n_err++; $display("FAIL to_next_rsp got v/e=%b want 10", {rsp_valid, rsp_err}); end
        n_vec++; if (mem[10'h030] !== 32'h77) begin n_err++; $display("FAIL to_next_mem got %h want 77", mem[10'h030]); end
        ref_mem[10'h030] = 32'h77;
        step();
    endtask

    task automatic test_random_scoreboard();
        logic [DW-1:0] exp_q [$];
        logic [DW-1:0] e;
        int accepts, rsps; bit acc;
        accepts = 0; rsps = 0; cmd_valid = 1'b0;
        for (int cyc = 0; cyc < 3000 && (accepts < 100 || exp_q.size() > 0); cyc++) begin
            if (rsp_valid) begin
                rsps++;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL sb_extra_rsp got rsp with d=%h want none", rsp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({rsp_rdata, rsp_err} !== {e, 1'b0}) begin n_err++; $display("FAIL sb_rsp got d=%h e=%b want %h/0", rsp_rdata, rsp_err, e); end
                end
            end
            if (psel && !penable) begin
                n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL sb_setup_rdy got %b want 0", cmd_ready); end
            end
            slv_wait = $urandom_range(0, 2);
            if (!cmd_valid && accepts < 100 && $urandom_range(0, 3) != 0) begin
                cmd_valid = 1'b1;
                cmd_write = 1'($urandom_range(0, 1));
                cmd_addr  = AW'($urandom_range(0, 15));
                cmd_wdata = $urandom;
            end
            #1;
            acc = cmd_valid && cmd_ready;
            if (acc) begin
                accepts++;
                if (cmd_write) begin
                    ref_mem[cmd_addr] = cmd_wdata;
                    exp_q.push_back(32'h0);
                end else begin
                    exp_q.push_back(ref_mem[cmd_addr]);
                end
            end
            step();
            if (acc) cmd_valid = 1'b0;
        end
        n_vec++; if (accepts !== 100) begin n_err++; $display("FAIL sb_accepts got %0d want 100", accepts); end
        n_vec++; if (rsps !== 100) begin n_err++; $display("FAIL sb_rsps got %0d want 100", rsps); end
        n_vec++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL sb_pending got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_access();
        test_write_read();
        test_back_to_back();
        test_wait_states();
        test_timeout();
        test_random_scoreboard();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB requester (initiator): converts a simple valid/ready command interface into APB SETUP/ACCESS transfers and returns a one-cycle response pulse.
- Drives the slave-side APB bus of apb_mem (paddr, pwrite, psel, penable, pwdata; samples prdata, pready).
- Supports back-to-back transfers, with no idle cycle inserted between them.
- Includes a wait-state timeout, so a hung slave cannot lock the bus.

Parameters:
ADDR_WIDTH, 10, APB address width
DATA_WIDTH, 32, APB data width
TIMEOUT, 16, maximum ACCESS cycles allowed without pready; 0 disables the timeout

Ports:
pclk  in  1  APB clock; all state updates on rising edge
PRESET  in  1  asynchronous reset, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready at the pclk edge
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  transfer address
cmd_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for timeouts
rsp_err  out  1  qualified by rsp_valid; 1 = timeout abort
busy  out  1  high in SETUP or ACCESS
paddr  out  ADDR_WIDTH  APB address
pwrite  out  1  APB direction
psel  out  1  APB select
penable  out  1  APB enable
pwdata  out  DATA_WIDTH  APB write data
prdata  in  DATA_WIDTH  APB read data
pready  in  1  APB ready from slave

Behaviour:
- Reset (async, while PRESET=1):
  - state=IDLE, wait counter=0.
  - psel=0, penable=0, pwrite=0, paddr=0, pwdata=0.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - Reset mid-transfer drops psel/penable immediately; no response is issued for the aborted transfer.
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered except cmd_ready and busy, which decode from state and pready.
- cmd_ready:
  - 1 in IDLE.
  - 1 in ACCESS when pready=1 (completing cycle).
  - 1 in ACCESS when the timeout fires.
  - 0 otherwise, including all of SETUP.
- Accept:
  - Captures cmd_addr/cmd_write/cmd_wdata into paddr/pwrite/pwdata.
  - Next state is SETUP: psel=1, penable=0.
  - pwdata is loaded on reads too, but its value is don't-care.
- SETUP -> ACCESS unconditionally after 1 cycle: penable=1. paddr/pwrite/pwdata are stable from SETUP through the end of ACCESS.
- ACCESS with pready=0: remain in ACCESS; wait counter increments.
- ACCESS with pready=1 (completion) at edge E, in the cycle after E:
  - rsp_valid=1 and rsp_err=0.
  - rsp_rdata = prdata sampled at E if pwrite=0, else 0.
  - If a command is accepted at E: state=SETUP, psel stays 1, penable=0, new address/data loaded.
  - Otherwise: state=IDLE, psel=0, penable=0; paddr/pwrite/pwdata hold their last values.
- Timeout (TIMEOUT>0):
  - Wait counter is cleared on entry to ACCESS.
  - If pready=0 on the TIMEOUT-th ACCESS cycle, the transfer is aborted at that edge: psel=0, penable=0.
  - Cycle after abort: rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - A command presented at the abort edge is accepted exactly as on completion.
  - pready=1 on the TIMEOUT-th cycle counts as success, not timeout.
  - Counter width is $clog2(TIMEOUT+1); it never wraps.
- Latency and throughput:
  - Zero wait states: accept at edge N, SETUP in cycle N..N+1, ACCESS N+1..N+2, rsp_valid in cycle after edge N+2 (3 edges).
  - Back-to-back throughput: one transfer per 2 cycles.
- Response interface:
  - rsp_valid is a single-cycle pulse with no backpressure.
  - rsp_rdata/rsp_err hold their values until the next response.
- busy = (state!=IDLE).
- Protocol invariant: penable=1 only when psel=1, and only in the cycle after a SETUP cycle.

Test Plan:
1. Reset with PRESET=1 asserted mid-ACCESS (pready=0) -> psel=0, penable=0 immediately, with no pclk edge needed. After release: state IDLE, cmd_ready=1, no rsp_valid.
2. Write 0x2A5 = 0xABCD1234, then read 0x2A5 against apb_mem -> write: psel 2 cycles, penable 1 cycle, rsp_valid with rsp_err=0, rsp_rdata=0. Read: rsp_rdata=0xABCD1234.
3. cmd_valid held continuously for writes to 1, 2, 3 -> psel stays 1 across transfers; penable pattern 0,1,0,1,0,1; three rsp_valid pulses 2 cycles apart.
4. Slave inserts 3 wait states (pready low 3 ACCESS cycles) on read of 0x10 returning 0x5A5A5A5A -> paddr stable throughout; rsp_valid 3 cycles later than the zero-wait case; rsp_rdata=0x5A5A5A5A.
5. TIMEOUT=4, pready tied 0 -> abort after 4 ACCESS cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=0. Next command proceeds normally. Repeat with pready=1 on the 4th cycle -> rsp_err=0.
6. Command arrives during SETUP -> cmd_ready=0; accepted on the completion edge; no transfer lost or duplicated, confirmed by a scoreboard over 100 random read/write commands.
